vsm_seq: RTL and testbench

Sequencer for the vector-scalar multiply-accumulate unit (`vsm`), used to compute one matrix-vector product per job.

- Takes a job length, then accepts column/scalar beats over a valid/ready stream and drives `vsm` reset, enable and operands.
- Waits out the unit's result latency and presents the accumulated vector on a valid/ready result port.
- Sits between the weight/activation fetch logic and `vsm`; it is the only block that drives `vsm` control.

---
 rtl/vsm_seq_if.sv | 32 +++
 rtl/vsm_seq.sv | 111 +++++++++++
 tb/tb_vsm_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vsm_seq_if.sv
// Signal bundle between the vsm sequencer, its beat/result environment and the vsm unit.
interface vsm_seq_if #(
  parameter int SIZE = 3,
  parameter int CW   = 5
);
  logic                start;
  logic [CW-1:0]       n_cols;
  logic                in_valid;
  logic                in_ready;
  logic [8*SIZE-1:0]   in_col;
  logic [7:0]          in_scalar;
  logic                vsm_reset;
  logic                vsm_enable;
  logic [8*SIZE-1:0]   vsm_a;
  logic [7:0]          vsm_b;
  logic [8*SIZE-1:0]   vsm_out;
  logic                res_valid;
  logic                res_ready;
  logic [8*SIZE-1:0]   res_data;
  logic                busy;
  logic                done;

  modport master (
    output start, n_cols, in_valid, in_col, in_scalar, vsm_out, res_ready,
    input  in_ready, vsm_reset, vsm_enable, vsm_a, vsm_b, res_valid, res_data, busy, done
  );

  modport slave (
    input  start, n_cols, in_valid, in_col, in_scalar, vsm_out, res_ready,
    output in_ready, vsm_reset, vsm_enable, vsm_a, vsm_b, res_valid, res_data, busy, done
  );
endinterface

// File: rtl/vsm_seq.sv
// Job sequencer for the vsm multiply-accumulate unit: clears it, streams column beats,
// waits out its latency and holds the accumulated vector until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for start; length latched on start
// CLEAR | one-cycle vsm_reset pulse
// FEED  | accepting beats, each one enables vsm combinationally
// DRAIN | waiting VSM_LAT cycles for vsm_out to settle, then capture
// HOLD  | result presented until res_ready
module vsm_seq #(
  parameter int SIZE     = 3,
  parameter int MAX_COLS = 16,
  parameter int VSM_LAT  = 1,
  parameter int CW       = $clog2(MAX_COLS + 1)
) (
  input  logic      clk,
  input  logic      reset,
  vsm_seq_if.slave  bus
);

  localparam int             LW       = (VSM_LAT > 1) ? $clog2(VSM_LAT) : 1;
  localparam logic [LW-1:0]  LAT_INIT = LW'(VSM_LAT - 1);
  localparam logic [CW-1:0]  COLS_MAX = CW'(MAX_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [8*SIZE-1:0]  res_q, res_d;
  logic               done_q, done_d;
  logic               xfer;

  assign xfer = (state_q == S_FEED) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      lat_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = (bus.n_cols > COLS_MAX) ? COLS_MAX : bus.n_cols;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        lat_d   = LAT_INIT;
        state_d = (rem_q != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        lat_d = LAT_INIT;
        if (xfer) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lat_q == '0) begin
          res_d   = bus.vsm_out;
          state_d = S_HOLD;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat path to vsm stays combinational so a transfer and its MAC share one edge.
  assign bus.in_ready   = (state_q == S_FEED);
  assign bus.vsm_reset  = (state_q == S_CLEAR);
  assign bus.vsm_enable = xfer;
  assign bus.vsm_a      = xfer ? bus.in_col    : '0;
  assign bus.vsm_b      = xfer ? bus.in_scalar : '0;
  assign bus.res_valid  = (state_q == S_HOLD);
  assign bus.res_data   = res_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_vsm_seq.sv
// Scoreboard bench for vsm_seq with a behavioural vsm accumulator model.
module tb_vsm_seq;
  localparam int SIZE     = 3;
  localparam int MAX_COLS = 16;
  localparam int VSM_LAT  = 1;
  localparam int CW       = $clog2(MAX_COLS + 1);
  localparam int DW       = 8 * SIZE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vsm_seq_if #(.SIZE(SIZE), .CW(CW)) bus ();

  vsm_seq #(
    .SIZE(SIZE), .MAX_COLS(MAX_COLS), .VSM_LAT(VSM_LAT), .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] bcol[32];
  logic [7:0]    bsc[32];
  logic [DW-1:0] acc = '0;

  function automatic logic [DW-1:0] mac(input logic [DW-1:0] s, input logic [DW-1:0] a,
                                        input logic [7:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < SIZE; l++) r[8*l +: 8] = s[8*l +: 8] + a[8*l +: 8] * b;
    return r;
  endfunction

  // vsm unit model: registered accumulator, one cycle from enabled edge to out.
  always @(posedge clk) begin
    if (bus.vsm_reset) acc <= '0;
    else if (bus.vsm_enable) acc <= mac(acc, bus.vsm_a, bus.vsm_b);
  end
  assign bus.vsm_out = acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) chk("res_unexpected", 32'(bus.res_data), 32'hFFFF_FFFF);
      else chk("res_data", 32'(bus.res_data), 32'(exp_q.pop_front()));
    end
    if (bus.done) n_done++;
  end

  task automatic set_basic();
    bcol[0] = 24'h010407; bsc[0] = 8'd1;
    bcol[1] = 24'h020508; bsc[1] = 8'd2;
    bcol[2] = 24'h030609; bsc[2] = 8'd3;
  endtask

  task automatic do_job(input int n, input bit gaps, input int hold_cyc, input bit retrig,
                        output int lat, output int beats, output logic [DW-1:0] res);
    int cyc, eff, d0;
    bit gap_now, got;
    logic [DW-1:0] e;
    eff = (n > MAX_COLS) ? MAX_COLS : n;
    e = '0;
    for (int i = 0; i < eff; i++) e = mac(e, bcol[i], bsc[i]);
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.n_cols = CW'(n); bus.res_ready = (hold_cyc == 0);
    @(negedge clk);
    bus.start = 1'b0; bus.n_cols = '0;
    cyc = 1; beats = 0; gap_now = 1'b0; got = 1'b0; lat = -1;
    while (cyc < 200 && !got) begin
      if (bus.res_valid) begin
        got = 1'b1;
        lat = cyc - 1;
      end else begin
        bus.in_valid = !gap_now; bus.in_col = bcol[beats]; bus.in_scalar = bsc[beats];
        #1;
        if (bus.in_ready && bus.in_valid) begin
          chk("beat_en", 32'(bus.vsm_enable), 32'd1);
          chk("beat_ab", {bus.vsm_a, bus.vsm_b}, {bcol[beats], bsc[beats]});
          beats++;
          gap_now = gaps;
        end else begin
          chk("idle_en", 32'(bus.vsm_enable), 32'd0);
          chk("idle_ab", {bus.vsm_a, bus.vsm_b}, 32'd0);
          gap_now = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    if (!got) chk("res_timeout", 32'd0, 32'd1);
    res = bus.res_data;
    d0 = n_done;
    for (int i = 0; i < hold_cyc; i++) begin
      if (retrig && i == 1) begin bus.start = 1'b1; bus.n_cols = CW'(2); end
      @(negedge clk);
      bus.start = 1'b0; bus.n_cols = '0;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'(res));
      chk("hold_nodone", 32'(bus.done), 32'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_once", 32'(bus.done), 32'd0);
    chk("stay_idle", 32'(bus.busy), 32'd0);
    chk("done_count", 32'(n_done - d0), 32'd1);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    int lat, beats;
    logic [DW-1:0] res;
    bus.start = 1'b0; bus.n_cols = '0; bus.in_valid = 1'b0; bus.in_col = '0;
    bus.in_scalar = '0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {26'd0, bus.in_ready, bus.vsm_reset, bus.vsm_enable, bus.res_valid,
                    bus.busy, bus.done}, 32'd0);
    chk("rst_data", 32'(bus.res_data), 32'd0);
    reset = 1'b0;

    // basic job
    set_basic();
    do_job(3, 1'b0, 0, 1'b0, lat, beats, res);
    chk("basic_lat", 32'(lat), 32'd5);
    chk("basic_beats", 32'(beats), 32'd3);
    chk("basic_const", 32'(res), 32'h0E2032);

    // one-cycle stalls between beats
    do_job(3, 1'b1, 0, 1'b0, lat, beats, res);
    chk("stall_lat", 32'(lat), 32'd7);
    chk("stall_const", 32'(res), 32'h0E2032);

    // back-pressure with a start pulse while holding
    do_job(3, 1'b0, 4, 1'b1, lat, beats, res);
    chk("bp_const", 32'(res), 32'h0E2032);

    // zero-length job
    do_job(0, 1'b0, 0, 1'b0, lat, beats, res);
    chk("zero_beats", 32'(beats), 32'd0);
    chk("zero_lat", 32'(lat), 32'd2);
    chk("zero_res", 32'(res), 32'd0);

    // clamped job
    for (int i = 0; i < 32; i++) begin
      bcol[i] = DW'($urandom);
      bsc[i]  = 8'($urandom);
    end
    do_job(MAX_COLS + 3, 1'b0, 0, 1'b0, lat, beats, res);
    chk("clamp_beats", 32'(beats), 32'(MAX_COLS));
    chk("clamp_lat", 32'(lat), 32'(MAX_COLS + 2));

    // lane wrap-around
    bcol[0] = 24'hFF8010; bsc[0] = 8'd2;
    bcol[1] = 24'hFF8010; bsc[1] = 8'd2;
    do_job(2, 1'b0, 0, 1'b0, lat, beats, res);
    chk("wrap_beats", 32'(beats), 32'd2);

    // reset after the first of three beats
    set_basic();
    @(negedge clk);
    bus.start = 1'b1; bus.n_cols = CW'(3);
    @(negedge clk);
    bus.start = 1'b0; bus.n_cols = '0;
    bus.in_valid = 1'b1; bus.in_col = bcol[0]; bus.in_scalar = bsc[0];
    @(negedge clk);
    chk("mid_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_col = bcol[1]; bus.in_scalar = bsc[1];
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_ctl", {26'd0, bus.in_ready, bus.vsm_reset, bus.vsm_enable, bus.res_valid,
                        bus.busy, bus.done}, 32'd0);
    chk("mid_rst_ab", {bus.vsm_a, bus.vsm_b}, 32'd0);
    chk("mid_rst_data", 32'(bus.res_data), 32'd0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    do_job(3, 1'b0, 0, 1'b0, lat, beats, res);
    chk("after_rst_const", 32'(res), 32'h0E2032);
    chk("after_rst_lat", 32'(lat), 32'd5);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
